uart_fifo_tx: RTL and testbench
===============================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL have parameter `width`, default 8, meaning data bits per frame (at least 5).
REQ-002 The block SHALL have parameter `stop_bits`, default 1, meaning stop bits per frame (1 or 2).
REQ-003 The block SHALL have parameter `div_width`, default 16, meaning width of the baud divider input.
REQ-004 The block SHALL have port `clk`, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port `tx_en`, input, 1 bit: permits starting new frames.
REQ-007 The block SHALL have port `clk_div`, input, `div_width` bits: clock cycles per bit.
REQ-008 The block SHALL have port `fifo_has_dat`, input, 1 bit: the source FIFO is not empty.
REQ-009 The block SHALL have port `fifo_rdata`, input, `width` bits: the head entry of the FIFO, valid combinationally while `fifo_has_dat` is 1.
REQ-010 The block SHALL have port `fifo_re`, output, 1 bit: pops the FIFO head at the next clock edge.
REQ-011 The block SHALL have port `txd`, output, 1 bit: serial line, idle-high.
REQ-012 The block SHALL have port `busy`, output, 1 bit: a frame is in progress.

Function
REQ-013 The block SHALL implement the states IDLE, START, DATA and STOP; `busy` = (state != IDLE).
REQ-014 `fifo_re` SHALL be combinational: 1 exactly when state is IDLE and `tx_en` = 1 and `fifo_has_dat` = 1 and `rst` = 0.
REQ-015 In a cycle with `fifo_re` = 1, the block SHALL perform these actions:
- latch `fifo_rdata` into the shift register;
- latch the bit period P = max(`clk_div`, 1) into the period register;
- enter START at the next edge.
REQ-016 The block SHALL assert `fifo_re` at most one cycle per frame and never while `busy` = 1.
REQ-017 `txd` SHALL be registered with the following value in each state:
- 1 in IDLE;
- 0 in START;
- the shift register LSB in DATA;
- 1 in STOP.
REQ-018 Each state SHALL last exactly P cycles per bit, timed by a down-counter reloaded with P-1 on every bit boundary.
REQ-019 DATA SHALL transmit `width` bits, LSB first, shifting right once per bit boundary.
REQ-020 Bit count transitions SHALL be as follows:
- START goes to DATA after 1 bit;
- DATA goes to STOP after `width` bits;
- STOP goes to IDLE after `stop_bits` bits.
REQ-021 Frame length SHALL be (1 + `width` + `stop_bits`) * P cycles of `busy` = 1.
REQ-022 Back-to-back frames SHALL be separated by exactly one IDLE cycle (`txd` = 1), the cycle in which `fifo_re` is asserted.
REQ-023 Changes to `clk_div` during a frame SHALL NOT affect that frame; they take effect at the next frame start.
REQ-024 `clk_div` = 0 SHALL behave identically to `clk_div` = 1.
REQ-025 When `tx_en` is deasserted mid-frame, the current frame SHALL complete normally and no new frame starts until `tx_en` = 1.
REQ-026 When `fifo_has_dat` = 0 in IDLE, the block SHALL remain in IDLE with `txd` = 1 and `fifo_re` = 0.
REQ-027 All counters SHALL be sized to hold `div_width` bits (period) and $clog2(`width`+1) bits (bit index) without overflow.

Reset
REQ-028 While `rst` = 1, the block SHALL hold the following: state = IDLE, `txd` = 1, `busy` = 0, `fifo_re` = 0, and counters and shift register = 0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame: `txd` = 1 from the edge where `rst` is sampled, and the abandoned entry is not re-read (it was already popped).
REQ-030 After `rst` deasserts, the first `fifo_re` SHALL occur no earlier than the first cycle with `rst` = 0.

Verification
REQ-031 width=8, stop_bits=1, clk_div=4, FIFO holds 0x55 -> `fifo_re` for 1 cycle; `txd` = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles; `busy` high 40 cycles.
REQ-032 FIFO holds 0xA3, 0x0F, clk_div=2 -> two frames of 20 busy cycles each, with exactly 1 idle cycle between them; `fifo_re` pulses twice; data bits observed LSB first match.
REQ-033 clk_div=0, byte 0xFF -> each bit lasts 1 cycle; frame = 10 busy cycles; `txd` low for only the start bit.
REQ-034 clk_div changed from 4 to 8 during data bit 3 -> the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
REQ-035 `rst` pulsed during data bit 5 -> `txd` = 1, `busy` = 0 next cycle; the FIFO is popped only once for that byte; the next byte starts normally after reset.
REQ-036 `tx_en` = 0 with FIFO non-empty -> no `fifo_re`, `txd` stays 1; dropping `tx_en` mid-frame -> the frame completes and no further pop occurs.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// UART transmitter fed from an external FIFO head: one frame of start, data (LSB first) and stop bits per popped entry.
// The bit period is captured at frame start, so clk_div may change freely while a frame is on the line.
module uart_fifo_tx #(
  parameter int width     = 8,
  parameter int stop_bits = 1,
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [div_width-1:0] clk_div,
  input  logic                 fifo_has_dat,
  input  logic [width-1:0]     fifo_rdata,
  output logic                 fifo_re,
  output logic                 txd,
  output logic                 busy
);

  localparam int BW = $clog2(width + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [width-1:0]     shift_r;
  logic [div_width-1:0] period_r;
  logic [div_width-1:0] cnt_r;
  logic [BW-1:0]        bit_r;
  logic                 txd_r;
  logic                 busy_r;
  logic [div_width-1:0] period_s;

  assign txd  = txd_r;
  assign busy = busy_r;

  // Pop request: only from IDLE, never while a reset is applied
  always_comb begin
    fifo_re = 1'b0;
    if ((state_r == IDLE) && tx_en && fifo_has_dat && !rst) begin
      fifo_re = 1'b1;
    end else begin
      fifo_re = 1'b0;
    end
  end

  // A zero divider is treated as one cycle per bit
  always_comb begin
    period_s = clk_div;
    if (clk_div == {div_width{1'b0}}) begin
      period_s = div_width'(1);
    end else begin
      period_s = clk_div;
    end
  end

  // Frame sequencer: state, bit timing, shift register and registered line/busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      shift_r  <= {width{1'b0}};
      period_r <= {div_width{1'b0}};
      cnt_r    <= {div_width{1'b0}};
      bit_r    <= {BW{1'b0}};
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          txd_r  <= 1'b1;
          busy_r <= 1'b0;
          if (fifo_re) begin
            shift_r  <= fifo_rdata;
            period_r <= period_s;
            cnt_r    <= period_s - div_width'(1);
            bit_r    <= {BW{1'b0}};
            txd_r    <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= START;
          end
        end
        START: begin
          if (cnt_r == {div_width{1'b0}}) begin
            cnt_r   <= period_r - div_width'(1);
            bit_r   <= {BW{1'b0}};
            txd_r   <= shift_r[0];
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r - div_width'(1);
          end
        end
        DATA: begin
          if (cnt_r == {div_width{1'b0}}) begin
            cnt_r   <= period_r - div_width'(1);
            shift_r <= shift_r >> 1;
            if (bit_r == BW'(width - 1)) begin
              bit_r   <= {BW{1'b0}};
              txd_r   <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_r <= bit_r + BW'(1);
              txd_r <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r - div_width'(1);
          end
        end
        STOP: begin
          if (cnt_r == {div_width{1'b0}}) begin
            cnt_r <= period_r - div_width'(1);
            if (bit_r == BW'(stop_bits - 1)) begin
              bit_r   <= {BW{1'b0}};
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              bit_r <= bit_r + BW'(1);
            end
          end else begin
            cnt_r <= cnt_r - div_width'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboarded bench for uart_fifo_tx: popped bytes become expected frames, a line monitor
// rebuilds each frame from txd/busy and compares it against start/data/stop timing rules.
module tb_uart_fifo_tx;
  localparam int W  = 8;
  localparam int SB = 1;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic [DW-1:0] clk_div;
  logic          fifo_has_dat;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_re;
  logic          txd;
  logic          busy;

  typedef struct {
    logic [W-1:0] data;
    int           period;
  } frame_t;

  logic [W-1:0] fq[$];
  frame_t       expq[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;

  always #5 clk = ~clk;

  uart_fifo_tx #(.width(W), .stop_bits(SB), .div_width(DW)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .clk_div(clk_div),
    .fifo_has_dat(fifo_has_dat), .fifo_rdata(fifo_rdata),
    .fifo_re(fifo_re), .txd(txd), .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input int bound);
    int t = 0;
    while (!busy && t < bound) begin
      cyc(1);
      t++;
    end
    if (t >= bound) chk("wait_busy_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while ((fq.size() != 0 || busy) && t < bound) begin
      cyc(1);
      t++;
    end
    if (t >= bound) chk("wait_idle_timeout", 1, 0);
    cyc(3);
  endtask

  // Compare a captured frame with the oldest expected frame
  task automatic check_frame(input logic smp[$]);
    frame_t f;
    int     bad;
    int     bitno;
    logic   e;
    if (expq.size() == 0) begin
      chk("frame_without_pop", 1, 0);
      return;
    end
    f = expq.pop_front();
    frames++;
    chk("frame_len", smp.size(), (1 + W + SB) * f.period);
    bad = 0;
    for (int k = 0; k < smp.size(); k++) begin
      bitno = k / f.period;
      if (bitno == 0) e = 1'b0;
      else if (bitno <= W) e = f.data[bitno-1];
      else e = 1'b1;
      if (smp[k] !== e) bad++;
    end
    chk("frame_bits", bad, 0);
  endtask

  // FIFO model: records the expected frame when a pop is seen, then retires the head
  initial begin
    forever begin
      bit pend;
      frame_t f;
      @(negedge clk);
      pend = 1'b0;
      if (fifo_re === 1'b1) begin
        if (fq.size() == 0) begin
          chk("pop_from_empty", 1, 0);
        end else begin
          f.data   = fq[0];
          f.period = (clk_div == 16'd0) ? 1 : int'(clk_div);
          expq.push_back(f);
          pend = 1'b1;
        end
      end
      @(posedge clk);
      #2;
      if (pend) void'(fq.pop_front());
      fifo_has_dat = (fq.size() != 0);
      fifo_rdata   = fifo_has_dat ? fq[0] : 8'h00;
    end
  end

  // Line monitor: pop rule, idle line level, reset response and frame capture
  initial begin
    logic smp[$];
    bit in_frame = 1'b0;
    bit prev_re  = 1'b0;
    bit rst_d    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
      end
      if (rst) chk("rst_fifo_re", fifo_re, 0);
      else chk("fifo_re_rule", fifo_re, (!busy && tx_en && fifo_has_dat) ? 1 : 0);
      if (rst && busy) begin
        if (expq.size() > 0) void'(expq.pop_front());
        in_frame = 1'b0;
        smp.delete();
      end else if (busy) begin
        if (!in_frame) begin
          chk("start_follows_pop", prev_re, 1);
          in_frame = 1'b1;
          smp.delete();
        end
        smp.push_back(txd);
      end else begin
        chk("idle_txd", txd, 1);
        if (in_frame) begin
          in_frame = 1'b0;
          check_frame(smp);
        end
      end
      prev_re = fifo_re;
      rst_d   = rst;
    end
  end

  initial begin
    rst = 1'b1; tx_en = 1'b0; clk_div = 16'd4; fifo_has_dat = 1'b0; fifo_rdata = 8'h00;
    cyc(3);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_re", fifo_re, 0);
    rst = 1'b0; tx_en = 1'b1;

    fq.push_back(8'h55);
    wait_idle(200);

    clk_div = 16'd2;
    fq.push_back(8'hA3); fq.push_back(8'h0F);
    wait_idle(200);

    clk_div = 16'd0;
    fq.push_back(8'hFF);
    wait_idle(100);

    // divider change lands in data bit 3 of the first frame
    clk_div = 16'd4;
    fq.push_back(8'h3C); fq.push_back(8'hC3);
    wait_busy(20);
    cyc(17);
    clk_div = 16'd8;
    wait_idle(400);

    // reset during data bit 5 abandons the frame without re-reading its byte
    clk_div = 16'd3;
    fq.push_back(8'h11); fq.push_back(8'h22);
    wait_busy(20);
    cyc(19);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("pop_once_on_reset", fq.size(), 1);
    wait_idle(200);

    tx_en = 1'b0;
    fq.push_back(8'h77);
    cyc(20);
    chk("tx_en_low_no_pop", fq.size(), 1);
    chk("tx_en_low_busy", busy, 0);
    tx_en = 1'b1;
    wait_busy(20);
    cyc(5);
    tx_en = 1'b0;
    fq.push_back(8'h88);
    begin
      int t = 0;
      while (busy && t < 200) begin
        cyc(1);
        t++;
      end
      if (t >= 200) chk("drop_tx_en_timeout", 1, 0);
    end
    cyc(10);
    chk("no_pop_after_tx_en_drop", fq.size(), 1);
    tx_en = 1'b1;
    wait_idle(200);

    repeat (600) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 4) fq.push_back(8'($urandom));
      if ($urandom_range(0, 19) == 0) clk_div = 16'($urandom_range(0, 5));
      tx_en = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    rst = 1'b0; tx_en = 1'b1;
    wait_idle(3000);

    chk("scoreboard_drained", expq.size(), 0);
    chk("frames_seen_nonzero", (frames > 10) ? 1 : 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
